// File: rtl/rr_chan_merge.sv
// rr_chan_merge: N-channel ingress merger. Each channel buffers into a private FIFO;
// a round-robin arbiter drains unmasked, non-empty FIFOs into one registered output.

module rr_chan_merge_chk #(
    parameter int WIDTH_S = 8,
    parameter int CH_NUM  = 4,
    parameter int DEPTH   = 4,
    parameter int CH_W    = 2,
    parameter int CNT_W   = 3
) (
    input logic                    clk,
    input logic                    rst_n,
    input logic [CH_NUM-1:0]       pop,
    input logic                    out_vld,
    input logic                    out_rdy,
    input logic [WIDTH_S-1:0]      out_data,
    input logic [CH_W-1:0]         out_ch,
    input logic [CH_NUM*CNT_W-1:0] fifo_lvl
);
    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (out_vld && !out_rdy) |=> (out_vld && $stable(out_data) && $stable(out_ch)));

    a_pop_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(pop));

    for (genvar i = 0; i < CH_NUM; i++) begin : g_lvl
        a_lvl: assert property (@(posedge clk) disable iff (!rst_n)
            fifo_lvl[i*CNT_W +: CNT_W] <= CNT_W'(DEPTH));
    end
endmodule

module rr_chan_merge #(
    parameter  int WIDTH_S = 8,
    parameter  int CH_NUM  = 4,
    parameter  int DEPTH   = 4,
    localparam int CH_W    = $clog2(CH_NUM),
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CH_NUM-1:0]         in_vld,
    output logic [CH_NUM-1:0]         in_rdy,
    input  logic [CH_NUM*WIDTH_S-1:0] in_data,
    input  logic [CH_NUM-1:0]         ch_mask,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic [WIDTH_S-1:0]        out_data,
    output logic [CH_W-1:0]           out_ch,
    output logic [CH_NUM*CNT_W-1:0]   fifo_lvl
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH_S-1:0] mem_r    [CH_NUM][DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r [CH_NUM];
    logic [PTR_W-1:0]   rd_ptr_r [CH_NUM];
    logic [CNT_W-1:0]   cnt_r    [CH_NUM];
    logic [CH_W-1:0]    last_gnt_r;
    logic               out_vld_r;
    logic [WIDTH_S-1:0] out_data_r;
    logic [CH_W-1:0]    out_ch_r;

    logic [CH_NUM-1:0]  in_rdy_s;
    logic [CH_NUM-1:0]  push_s;
    logic [CH_NUM-1:0]  pop_s;
    logic [CH_NUM-1:0]  elig_s;
    logic               ld_s;
    logic               hi_vld_s;
    logic               lo_vld_s;
    logic               gnt_vld_s;
    logic [CH_W-1:0]    hi_idx_s;
    logic [CH_W-1:0]    lo_idx_s;
    logic [CH_W-1:0]    gnt_idx_s;
    logic [WIDTH_S-1:0] head_data_s;

    // Per-channel status, decoded from registered counts so in_rdy never sees same-cycle pops
    always_comb begin
        in_rdy_s = {CH_NUM{1'b0}};
        elig_s   = {CH_NUM{1'b0}};
        push_s   = {CH_NUM{1'b0}};
        fifo_lvl = {(CH_NUM*CNT_W){1'b0}};
        for (int i = 0; i < CH_NUM; i++) begin
            in_rdy_s[i] = (cnt_r[i] != CNT_W'(DEPTH));
            elig_s[i]   = (cnt_r[i] != {CNT_W{1'b0}}) & ~ch_mask[i];
            push_s[i]   = in_vld[i] & in_rdy_s[i];
            fifo_lvl[i*CNT_W +: CNT_W] = cnt_r[i];
        end
    end

    // Round-robin pick: lowest eligible index above last_gnt_r, otherwise lowest eligible overall
    always_comb begin
        hi_vld_s    = 1'b0;
        hi_idx_s    = {CH_W{1'b0}};
        lo_vld_s    = 1'b0;
        lo_idx_s    = {CH_W{1'b0}};
        pop_s       = {CH_NUM{1'b0}};
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (elig_s[i] && (CH_W'(i) > last_gnt_r)) begin
                hi_vld_s = 1'b1;
                hi_idx_s = CH_W'(i);
            end else if (elig_s[i]) begin
                lo_vld_s = 1'b1;
                lo_idx_s = CH_W'(i);
            end else begin
                lo_vld_s = lo_vld_s;
            end
        end
        gnt_vld_s   = hi_vld_s | lo_vld_s;
        gnt_idx_s   = hi_vld_s ? hi_idx_s : lo_idx_s;
        ld_s        = ~out_vld_r | out_rdy;
        for (int i = 0; i < CH_NUM; i++) begin
            pop_s[i] = ld_s & gnt_vld_s & (gnt_idx_s == CH_W'(i));
        end
        head_data_s = mem_r[gnt_idx_s][rd_ptr_r[gnt_idx_s]];
    end

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < CH_NUM; i++) begin
            if (push_s[i]) begin
                mem_r[i][wr_ptr_r[i]] <= in_data[i*WIDTH_S +: WIDTH_S];
            end
        end
    end

    // FIFO pointers and occupancy counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH_NUM; i++) begin
                wr_ptr_r[i] <= {PTR_W{1'b0}};
                rd_ptr_r[i] <= {PTR_W{1'b0}};
                cnt_r[i]    <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (push_s[i]) begin
                    wr_ptr_r[i] <= wr_ptr_r[i] + PTR_W'(1);
                end
                if (pop_s[i]) begin
                    rd_ptr_r[i] <= rd_ptr_r[i] + PTR_W'(1);
                end
                case ({push_s[i], pop_s[i]})
                    2'b10:   cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                    2'b01:   cnt_r[i] <= cnt_r[i] - CNT_W'(1);
                    default: cnt_r[i] <= cnt_r[i];
                endcase
            end
        end
    end

    // Output register and grant pointer; reset pointer makes channel 0 first in line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_r  <= 1'b0;
            out_data_r <= {WIDTH_S{1'b0}};
            out_ch_r   <= {CH_W{1'b0}};
            last_gnt_r <= CH_W'(CH_NUM - 1);
        end else if (ld_s && gnt_vld_s) begin
            out_vld_r  <= 1'b1;
            out_data_r <= head_data_s;
            out_ch_r   <= gnt_idx_s;
            last_gnt_r <= gnt_idx_s;
        end else if (ld_s) begin
            out_vld_r  <= 1'b0;
        end else begin
            out_vld_r  <= out_vld_r;
        end
    end

    assign in_rdy   = in_rdy_s;
    assign out_vld  = out_vld_r;
    assign out_data = out_data_r;
    assign out_ch   = out_ch_r;

    rr_chan_merge_chk #(
        .WIDTH_S (WIDTH_S),
        .CH_NUM  (CH_NUM),
        .DEPTH   (DEPTH),
        .CH_W    (CH_W),
        .CNT_W   (CNT_W)
    ) u_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .pop      (pop_s),
        .out_vld  (out_vld_r),
        .out_rdy  (out_rdy),
        .out_data (out_data_r),
        .out_ch   (out_ch_r),
        .fifo_lvl (fifo_lvl)
    );
endmodule

// File: tb/tb_rr_chan_merge.sv
// Directed bench for rr_chan_merge (CH_NUM=4, WIDTH_S=8, DEPTH=4): a vector table
// for single-channel traffic plus hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_rr_chan_merge;
    localparam int WIDTH_S = 8;
    localparam int CH_NUM  = 4;
    localparam int DEPTH   = 4;
    localparam int CH_W    = 2;
    localparam int CNT_W   = 3;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [CH_NUM-1:0]         in_vld = 4'h0;
    logic [CH_NUM-1:0]         in_rdy;
    logic [CH_NUM*WIDTH_S-1:0] in_data = 32'h0;
    logic [CH_NUM-1:0]         ch_mask = 4'h0;
    logic                      out_vld;
    logic                      out_rdy = 1'b0;
    logic [WIDTH_S-1:0]        out_data;
    logic [CH_W-1:0]           out_ch;
    logic [CH_NUM*CNT_W-1:0]   fifo_lvl;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  vld;
        logic [31:0] data;
        logic [3:0]  mask;
        logic        rdy;
        logic        e_vld;
        logic [7:0]  e_data;
        logic [1:0]  e_ch;
        logic [11:0] e_lvl;
        logic [3:0]  e_rdy;
    } vec_t;

    vec_t        vec [17];
    logic [1:0]  m_ch   [6];
    logic [7:0]  m_data [6];
    int          rd_idx [4];
    int          received;
    logic        hold_prev;
    logic [7:0]  prev_data;
    logic [1:0]  prev_ch;
    logic [1:0]  ch_v;

    rr_chan_merge #(.WIDTH_S(WIDTH_S), .CH_NUM(CH_NUM), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .ch_mask  (ch_mask),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_ch   (out_ch),
        .fifo_lvl (fifo_lvl)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        in_vld  = 4'h0;
        in_data = 32'h0;
        ch_mask = 4'h0;
        out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //           vld     data          mask  rdy  e_vld e_data e_ch  e_lvl    e_rdy
        vec[0]  = '{4'b0100, 32'h00A50000, 4'h0, 1'b1, 1'b0, 8'h00, 2'd0, 12'h040, 4'hF};
        vec[1]  = '{4'b0000, 32'h00000000, 4'h0, 1'b0, 1'b1, 8'hA5, 2'd2, 12'h000, 4'hF};
        vec[2]  = '{4'b0000, 32'h00000000, 4'h0, 1'b0, 1'b1, 8'hA5, 2'd2, 12'h000, 4'hF};
        vec[3]  = '{4'b0000, 32'h00000000, 4'h0, 1'b1, 1'b0, 8'h00, 2'd0, 12'h000, 4'hF};
        vec[4]  = '{4'b0010, 32'h00002000, 4'h0, 1'b0, 1'b0, 8'h00, 2'd0, 12'h008, 4'hF};
        vec[5]  = '{4'b0010, 32'h00002100, 4'h0, 1'b0, 1'b1, 8'h20, 2'd1, 12'h008, 4'hF};
        vec[6]  = '{4'b0010, 32'h00002200, 4'h0, 1'b0, 1'b1, 8'h20, 2'd1, 12'h010, 4'hF};
        vec[7]  = '{4'b0010, 32'h00002300, 4'h0, 1'b0, 1'b1, 8'h20, 2'd1, 12'h018, 4'hF};
        vec[8]  = '{4'b0010, 32'h00002400, 4'h0, 1'b0, 1'b1, 8'h20, 2'd1, 12'h020, 4'hD};
        vec[9]  = '{4'b0010, 32'h00002500, 4'h0, 1'b0, 1'b1, 8'h20, 2'd1, 12'h020, 4'hD};
        vec[10] = '{4'b0010, 32'h00002500, 4'h0, 1'b1, 1'b1, 8'h21, 2'd1, 12'h018, 4'hF};
        vec[11] = '{4'b0010, 32'h00002500, 4'h0, 1'b0, 1'b1, 8'h21, 2'd1, 12'h020, 4'hD};
        vec[12] = '{4'b0000, 32'h00000000, 4'h0, 1'b1, 1'b1, 8'h22, 2'd1, 12'h018, 4'hF};
        vec[13] = '{4'b0000, 32'h00000000, 4'h0, 1'b1, 1'b1, 8'h23, 2'd1, 12'h010, 4'hF};
        vec[14] = '{4'b0000, 32'h00000000, 4'h0, 1'b1, 1'b1, 8'h24, 2'd1, 12'h008, 4'hF};
        vec[15] = '{4'b0000, 32'h00000000, 4'h0, 1'b1, 1'b1, 8'h25, 2'd1, 12'h000, 4'hF};
        vec[16] = '{4'b0000, 32'h00000000, 4'h0, 1'b1, 1'b0, 8'h00, 2'd0, 12'h000, 4'hF};
        m_ch   = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1};
        m_data = '{8'h00, 8'h01, 8'h10, 8'h02, 8'h11, 8'h12};

        // Reset values
        do_reset();
        check("rst_out_vld", 32'(out_vld), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_ch", 32'(out_ch), 32'h0);
        check("rst_fifo_lvl", 32'(fifo_lvl), 32'h0);
        check("rst_in_rdy", 32'(in_rdy), 32'hF);

        // Single-channel latency, fill to full with stalled output, drain in order
        for (int r = 0; r < 17; r++) begin
            in_vld  = vec[r].vld;
            in_data = vec[r].data;
            ch_mask = vec[r].mask;
            out_rdy = vec[r].rdy;
            step();
            check($sformatf("row%0d_vld", r), 32'(out_vld), 32'(vec[r].e_vld));
            if (vec[r].e_vld) begin
                check($sformatf("row%0d_data", r), 32'(out_data), 32'(vec[r].e_data));
                check($sformatf("row%0d_ch", r), 32'(out_ch), 32'(vec[r].e_ch));
            end
            check($sformatf("row%0d_lvl", r), 32'(fifo_lvl), 32'(vec[r].e_lvl));
            check($sformatf("row%0d_rdy", r), 32'(in_rdy), 32'(vec[r].e_rdy));
        end

        // Round-robin over four backlogged channels
        do_reset();
        for (int j = 0; j < 3; j++) begin
            in_vld  = 4'hF;
            in_data = {8'h30 + 8'(j), 8'h20 + 8'(j), 8'h10 + 8'(j), 8'h00 + 8'(j)};
            step();
        end
        in_vld  = 4'h0;
        out_rdy = 1'b1;
        for (int k = 0; k < 12; k++) begin
            check($sformatf("rr%0d_vld", k), 32'(out_vld), 32'h1);
            check($sformatf("rr%0d_ch", k), 32'(out_ch), 32'(k % 4));
            check($sformatf("rr%0d_data", k), 32'(out_data), 32'(16 * (k % 4) + k / 4));
            step();
        end
        check("rr_end_vld", 32'(out_vld), 32'h0);
        check("rr_end_lvl", 32'(fifo_lvl), 32'h0);

        // Mask excludes channel 1, then alternation resumes
        do_reset();
        ch_mask = 4'b0010;
        for (int j = 0; j < 3; j++) begin
            in_vld  = 4'b0011;
            in_data = {16'h0000, 8'h10 + 8'(j), 8'h00 + 8'(j)};
            step();
        end
        in_vld = 4'h0;
        check("mask_lvl", 32'(fifo_lvl), 32'h01A);
        out_rdy = 1'b1;
        for (int j = 0; j < 6; j++) begin
            check($sformatf("mask%0d_vld", j), 32'(out_vld), 32'h1);
            check($sformatf("mask%0d_ch", j), 32'(out_ch), 32'(m_ch[j]));
            check($sformatf("mask%0d_data", j), 32'(out_data), 32'(m_data[j]));
            if (j == 1) ch_mask = 4'h0;
            step();
        end
        check("mask_end_vld", 32'(out_vld), 32'h0);

        // Toggling out_rdy under backlog: stability and scoreboard
        do_reset();
        received  = 0;
        hold_prev = 1'b0;
        prev_data = 8'h00;
        prev_ch   = 2'd0;
        for (int i = 0; i < 4; i++) rd_idx[i] = 0;
        for (int c = 0; c < 60; c++) begin
            if (c < 4) begin
                in_vld  = 4'hF;
                in_data = {8'hB0 + 8'(c), 8'hA0 + 8'(c), 8'h90 + 8'(c), 8'h80 + 8'(c)};
            end else begin
                in_vld  = 4'h0;
            end
            out_rdy = (c % 2 == 0);
            if (hold_prev) begin
                check("stall_vld", 32'(out_vld), 32'h1);
                check("stall_data", 32'(out_data), 32'(prev_data));
                check("stall_ch", 32'(out_ch), 32'(prev_ch));
            end
            if (out_vld && out_rdy) begin
                ch_v = out_ch;
                check("sb_data", 32'(out_data),
                      (rd_idx[ch_v] < 4) ? 32'(8'h80 + {ch_v, 4'h0} + 8'(rd_idx[ch_v])) : 32'h1FF);
                rd_idx[ch_v]++;
                received++;
            end
            hold_prev = out_vld && !out_rdy;
            prev_data = out_data;
            prev_ch   = out_ch;
            step();
            if (received == 16) break;
        end
        in_vld = 4'h0;
        check("sb_total", 32'(received), 32'd16);
        check("sb_end_vld", 32'(out_vld), 32'h0);
        check("sb_end_lvl", 32'(fifo_lvl), 32'h0);

        // Asynchronous reset with data buffered and output valid
        do_reset();
        in_vld  = 4'b1010;
        in_data = 32'h63006100;
        step();
        in_vld  = 4'b0010;
        in_data = 32'h00006200;
        step();
        in_vld  = 4'h0;
        check("pre_rst_vld", 32'(out_vld), 32'h1);
        check("pre_rst_data", 32'(out_data), 32'h61);
        check("pre_rst_lvl", 32'(fifo_lvl), 32'h208);
        #2 rst_n = 1'b0;
        #1;
        check("arst_vld", 32'(out_vld), 32'h0);
        check("arst_data", 32'(out_data), 32'h0);
        check("arst_ch", 32'(out_ch), 32'h0);
        check("arst_lvl", 32'(fifo_lvl), 32'h0);
        check("arst_rdy", 32'(in_rdy), 32'hF);
        @(posedge clk);
        #1 rst_n = 1'b1;
        in_vld  = 4'b1101;
        in_data = 32'h73720070;
        out_rdy = 1'b1;
        step();
        in_vld  = 4'h0;
        check("post_push_vld", 32'(out_vld), 32'h0);
        step();
        check("post0_ch", 32'(out_ch), 32'h0);
        check("post0_data", 32'(out_data), 32'h70);
        step();
        check("post1_ch", 32'(out_ch), 32'h2);
        check("post1_data", 32'(out_data), 32'h72);
        step();
        check("post2_ch", 32'(out_ch), 32'h3);
        check("post2_data", 32'(out_data), 32'h73);
        step();
        check("post_end_vld", 32'(out_vld), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
